mw_add_seq: RTL and testbench

MW_ADD_SEQ -- requirements
Module: mw_add_seq

---
 rtl/mw_add_pkg.sv | 6 +
 rtl/mw_add_seq_adder_cin.sv | 12 +
 rtl/mw_add_seq.sv | 79 +++++++
 tb/tb_mw_add_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mw_add_pkg.sv
// mw_add_pkg: shared FSM state type and default geometry for the chunked multi-word adder.
package mw_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_W = 8;
  localparam int DEF_K = 4;
endpackage

// File: rtl/mw_add_seq_adder_cin.sv
// adder_cin: combinational W-bit adder with carry-in and carry-out.
module adder_cin #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mw_add_seq.sv
// mw_add_seq: K-chunk sequential add/subtract, LSB chunk first, with carry/overflow/zero flags.
// Define MW_ADD_SUB_EN to add the sub port and subtract mode.
module mw_add_seq
  import mw_add_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = DEF_K
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x_chunk,
  input  logic [W-1:0]   y_chunk,
`ifdef MW_ADD_SUB_EN
  input  logic           sub,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K*W-1:0] s,
  output logic           c,
  output logic           o,
  output logic           z
);
  localparam int CW = K > 1 ? $clog2(K) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic carry, accept, first, last, sub_act, cin, co;
  logic [W-1:0] y_eff, sum;
  assign accept = in_valid && in_ready;
  assign first = state == IDLE;
  assign last = cnt == CW'(K - 1);
`ifdef MW_ADD_SUB_EN
  logic sub_mode;
  // Subtract mode is taken from the port on the first beat, then held for the operand.
  assign sub_act = first ? sub : sub_mode;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sub_mode <= 1'b0;
    else if (accept && first) sub_mode <= sub;
`else
  assign sub_act = 1'b0;
`endif
  assign y_eff = sub_act ? ~y_chunk : y_chunk;
  assign cin = first ? sub_act : carry;
  adder_cin #(.W(W)) u_add (.a(x_chunk), .b(y_eff), .cin(cin), .sum(sum), .co(co));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      s         <= '0;
      c         <= 1'b0;
      o         <= 1'b0;
      z         <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (accept) begin
      s[int'(cnt)*W +: W] <= sum;
      carry <= co;
      z     <= (first | z) & ~|sum;
      if (last) begin
        state     <= DONE;
        cnt       <= '0;
        c         <= co;
        o         <= ~(x_chunk[W-1] ^ y_eff[W-1]) & (sum[W-1] ^ x_chunk[W-1]);
        in_ready  <= 1'b0;
        out_valid <= 1'b1;
      end else begin
        state <= RUN;
        cnt   <= cnt + CW'(1);
      end
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mw_add_seq.sv
// tb_mw_add_seq: randomized + directed scoreboard bench for mw_add_seq (W=8, K=4); MW_ADD_SUB_EN adds subtract cases.
module tb_mw_add_seq;
  localparam int W = 8;
  localparam int K = 4;
  localparam int KW = K * W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] x_chunk = '0;
  logic [W-1:0] y_chunk = '0;
  logic in_ready, out_valid, c, o, z;
  logic [KW-1:0] s;
`ifdef MW_ADD_SUB_EN
  logic sub = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  int force_stall = 0;
  bit rand_ready = 1'b0;
  logic [KW+2:0] sb_q[$];

  mw_add_seq #(.W(W), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_chunk(x_chunk), .y_chunk(y_chunk),
`ifdef MW_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c(c), .o(o), .z(z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operand reference: one full-width add, independent of chunking.
  function automatic logic [KW+2:0] model(input logic [KW-1:0] x, input logic [KW-1:0] y, input logic sb);
    logic [KW-1:0] ye;
    logic [KW:0] r;
    logic ov;
    ye = sb ? ~y : y;
    r = {1'b0, x} + {1'b0, ye} + {{KW{1'b0}}, sb};
    ov = (x[KW-1] == ye[KW-1]) && (r[KW-1] != x[KW-1]);
    return {r[KW-1:0], r[KW], ov, r[KW-1:0] == '0};
  endfunction

  task automatic send_beat(input logic [W-1:0] xc, input logic [W-1:0] yc);
    int t;
    in_valid = 1'b1;
    x_chunk = xc;
    y_chunk = yc;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_chunk = $urandom;
    y_chunk = $urandom;
  endtask

  task automatic send_op(input logic [KW-1:0] x, input logic [KW-1:0] y, input logic sb, input int gap);
    sb_q.push_back(model(x, y, sb));
    for (int i = 0; i < K; i++) begin
`ifdef MW_ADD_SUB_EN
      sub = (i == 0) ? sb : 1'($urandom);
`endif
      send_beat(x[i*W +: W], y[i*W +: W]);
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s"}, s, '0);
    chk({tag, "_c"}, KW'(c), '0);
    chk({tag, "_o"}, KW'(o), '0);
    chk({tag, "_z"}, KW'(z), '0);
    chk({tag, "_out_valid"}, KW'(out_valid), '0);
    chk({tag, "_in_ready"}, KW'(in_ready), KW'(1));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (force_stall > 0 && out_valid) begin
        out_ready = 1'b0;
        force_stall--;
      end else out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: every cycle a result is presented it must match the head of the scoreboard.
  initial begin
    logic [KW+2:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        chk("in_ready_in_done", KW'(in_ready), '0);
        if (sb_q.size() == 0) chk("unexpected_result", KW'(1), '0);
        else begin
          e = sb_q[0];
          chk("s", s, e[KW+2:3]);
          chk("c", KW'(c), KW'(e[2]));
          chk("o", KW'(o), KW'(e[1]));
          chk("z", KW'(z), KW'(e[0]));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");
    @(posedge clk);
    #1;
    send_op(32'h000000FF, 32'h00000001, 1'b0, 0);
    send_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    send_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    force_stall = 3;
    send_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 2);
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    send_beat(8'h11, 8'h22);
    send_beat(8'h33, 8'h44);
    rst_n = 1'b0;
    #3;
    chk_zero("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_mid_reset");
    @(posedge clk);
    #1;
    send_op(32'h00000003, 32'h00000004, 1'b0, 0);
`ifdef MW_ADD_SUB_EN
    send_op(32'h00000005, 32'h00000007, 1'b1, 0);
`endif
    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      logic [KW-1:0] rx, ry;
      logic rs;
      rx = $urandom;
      ry = $urandom;
      if (i % 5 == 0) ry = -rx;
`ifdef MW_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      send_op(rx, ry, rs, $urandom_range(0, 2));
    end
    t = 0;
    while (sb_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", KW'(sb_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
